// File: rtl/seven_seg_scanner.sv
`timescale 1ns/1ps
// seven_seg_scanner
// Time-multiplexed driver for a common-anode seven-segment bank. Each
// digit owns a slot of PRESCALE clocks. The first BLANK_CYCLES clocks of
// every slot keep all anodes off so the previous digit's pattern cannot
// ghost. Register writes are staged and only reach the display registers
// at a frame boundary, so a frame is never drawn from mixed data.
//
// Optional feature: define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   value      4*N_DIGITS hex nibbles, nibble i -> digit i
//   dp_in      decimal point per digit (1 = lit)
//   digit_en   per-digit enable (1 = digit may light)
//   load       capture value/dp_in/digit_en this cycle
//   pending    staged data waiting for the next frame boundary
//   frame_tick one-cycle pulse after the last slot of a frame
//   seg        segments, seg[6]=g .. seg[0]=a
//   dp         decimal point
//   an         anodes, an[i] selects digit i
module seven_seg_scanner #(
  parameter int N_DIGITS     = 8,
  parameter int PRESCALE     = 16384,
  parameter int BLANK_CYCLES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic                  slot_end;
  logic                  boundary;

  logic [4*N_DIGITS-1:0] disp_val, stg_val;
  logic [N_DIGITS-1:0]   disp_dp, stg_dp;
  logic [N_DIGITS-1:0]   disp_en, stg_en;

  logic [3:0]            cur_nib;
  logic                  cur_en;
  logic                  cur_dp;
  logic                  suppress;
  logic                  lit;
  logic [N_DIGITS-1:0]   an_hi;
  logic [6:0]            seg_hi;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      4'hF: hex7 = 7'b1110001;
    endcase
  endfunction

  assign slot_end = (pcnt == PCNT_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // A load on the boundary cycle goes straight to the display registers;
  // anything staged earlier in the frame is superseded by it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      disp_val <= '0;
      disp_dp  <= '0;
      disp_en  <= '1;
      stg_val  <= '0;
      stg_dp   <= '0;
      stg_en   <= '0;
    end else if (boundary) begin
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
        disp_en  <= digit_en;
      end else if (pending) begin
        disp_val <= stg_val;
        disp_dp  <= stg_dp;
        disp_en  <= stg_en;
      end
      pending <= 1'b0;
    end else if (load) begin
      stg_val <= value;
      stg_dp  <= dp_in;
      stg_en  <= digit_en;
      pending <= 1'b1;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = disp_val[i*4 +: 4];
        cur_en  = disp_en[i];
        cur_dp  = disp_dp[i];
      end
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // zero_from[i]: digit i and every digit above it read as zero, with
  // disabled digits counting as zero.
  logic [N_DIGITS-1:0] zero_from;
  logic                zero_run;

  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (!disp_en[i] || (disp_val[i*4 +: 4] == 4'h0));
      zero_from[i] = zero_run;
    end
  end

  always_comb begin
    suppress = 1'b0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) suppress = zero_from[i];
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign lit    = (pcnt >= BLANK_END) && cur_en && !suppress;
  assign seg_hi = lit ? hex7(cur_nib) : 7'b0000000;

  always_comb begin
    an_hi = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      an_hi[i] = lit && (idx == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= {N_DIGITS{POL}};
      seg        <= {7{POL}};
      dp         <= POL;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_hi ^ {N_DIGITS{POL}};
      seg        <= seg_hi ^ {7{POL}};
      dp         <= (lit && cur_dp) ^ POL;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
`timescale 1ns/1ps
module tb_seven_seg_scanner;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        load = 1'b0;
  logic        pending;
  logic        frame_tick;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  seven_seg_scanner #(
    .N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .load(load), .pending(pending),
    .frame_tick(frame_tick), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", tag, $time, got, want);
    end
  endtask

  function automatic logic [6:0] ref_hex(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
          7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
          7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
          7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    return t[h];
  endfunction

  // reference model state (reflects the DUT state before the next edge)
  int          m_pcnt, m_idx;
  logic        m_pend;
  logic [15:0] m_val, s_val;
  logic [3:0]  m_dp, s_dp, m_en, s_en;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       pend;
  } exp_t;
  exp_t sb_q[$];

  function automatic bit model_lit();
    bit l;
    l = (m_pcnt >= B) && m_en[m_idx];
`ifdef SEVEN_SEG_LZB_EN
    if (m_idx > 0) begin
      bit allz = 1'b1;
      for (int j = m_idx; j < N; j++)
        if (m_en[j] && m_val[j*4 +: 4] != 4'h0) allz = 1'b0;
      if (allz) l = 1'b0;
    end
`endif
    return l;
  endfunction

  // One clock: predict the pins after the coming edge, push, clock, pop, compare.
  task automatic tick();
    exp_t e;
    exp_t o;
    bit   l;
    bit   bnd;
    if (!rst_n) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0; e.pend = 1'b0;
      m_pcnt = 0; m_idx = 0; m_pend = 1'b0;
      m_val = '0; m_dp = '0; m_en = 4'hF;
      s_val = '0; s_dp = '0; s_en = '0;
    end else begin
      l = model_lit();
      bnd = (m_pcnt == P-1) && (m_idx == N-1);
      e.an  = l ? ~(4'b0001 << m_idx) : 4'hF;
      e.seg = l ? ~ref_hex(m_val[m_idx*4 +: 4]) : 7'h7F;
      e.dp  = l ? ~m_dp[m_idx] : 1'b1;
      e.ft  = bnd;
      if (bnd) begin
        if (load) begin
          m_val = value; m_dp = dp_in; m_en = digit_en;
        end else if (m_pend) begin
          m_val = s_val; m_dp = s_dp; m_en = s_en;
        end
        m_pend = 1'b0;
      end else if (load) begin
        s_val = value; s_dp = dp_in; s_en = digit_en;
        m_pend = 1'b1;
      end
      if (m_pcnt == P-1) begin
        m_pcnt = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_pcnt++;
      end
      e.pend = m_pend;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk_val("sb_an", an, o.an);
    chk_val("sb_seg", seg, o.seg);
    chk_val("sb_dp", dp, o.dp);
    chk_val("sb_frame_tick", frame_tick, o.ft);
    chk_val("sb_pending", pending, o.pend);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_ft();
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    if (frame_tick !== 1'b1) chk_val("ft_timeout", frame_tick, 1);
  endtask

  task automatic wait_pos(input int p, input int i);
    int n = 0;
    while (!(m_pcnt == p && m_idx == i) && n < 100) begin
      tick();
      n++;
    end
    if (!(m_pcnt == p && m_idx == i)) chk_val("pos_timeout", m_pcnt, p);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
    value = v; dp_in = d; digit_en = en; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  int lit_cnt [4];
  logic [3:0] an_seen;
  int dp_cnt;

  // Called right after frame_tick is observed: the next 32 outputs are one frame.
  task automatic scan_frame();
    for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
    an_seen = '0;
    dp_cnt = 0;
    for (int k = 0; k < N*P; k++) begin
      tick();
      an_seen |= ~an;
      for (int i = 0; i < 4; i++) if (!an[i]) lit_cnt[i]++;
      if (!dp) begin
        dp_cnt++;
        chk_val("dp_slot0_only", an, 4'b1110);
      end
    end
  endtask

  initial begin
    int n;

    // 1: reset, load ignored while in reset
    rst_n = 1'b0; load = 1'b1; value = 16'hFFFF;
    ticks(3);
    chk_val("rst_an", an, 4'b1111);
    chk_val("rst_seg", seg, 7'b1111111);
    chk_val("rst_dp", dp, 1'b1);
    chk_val("rst_pending", pending, 1'b0);
    load = 1'b0; rst_n = 1'b1;
    tick(); chk_val("rel1_an", an, 4'b1111);
    tick(); chk_val("rel2_an", an, 4'b1111);
    tick();
    chk_val("first_lit_an", an, 4'b1110);
    chk_val("first_lit_seg", seg, 7'b1000000);

    // 2: 12AF shown after one boundary, blank interval, frame period
    do_load(16'h12AF, 4'h0, 4'hF);
    wait_ft();
    tick(); chk_val("blank0_an", an, 4'b1111);
    tick(); chk_val("blank1_an", an, 4'b1111);
    tick();
    chk_val("d0_F_an", an, 4'b1110);
    chk_val("d0_F_seg", seg, 7'b0001110);
    wait_ft();
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    chk_val("frame_period", n, 32);

    // 3: mid-frame load stays pending until the boundary
    wait_pos(2, 1);
    do_load(16'h1234, 4'h0, 4'hF);
    chk_val("mid_pending", pending, 1'b1);
    wait_ft();
    chk_val("post_ft_pending", pending, 1'b0);
    ticks(3);
    chk_val("d0_4_seg", seg, 7'b0011001);

    // 4: last write wins; boundary load bypasses staging
    wait_pos(1, 0);
    do_load(16'hAAAA, 4'h0, 4'hF);
    do_load(16'h5555, 4'h0, 4'hF);
    wait_ft();
    ticks(3);
    chk_val("d0_5_seg", seg, 7'b0010010);
    wait_pos(P-1, N-1);
    do_load(16'h9999, 4'h0, 4'hF);
    chk_val("bnd_load_pending", pending, 1'b0);
    chk_val("bnd_load_ft", frame_tick, 1'b1);
    ticks(3);
    chk_val("d0_9_seg", seg, 7'b0010000);

    // 5: digit enable and dp masks
    wait_pos(1, 0);
    do_load(16'h9999, 4'b0001, 4'b0101);
    wait_ft();
    scan_frame();
    chk_val("masked_an", an_seen & 4'b1010, 4'b0000);
    chk_val("lit_an", an_seen, 4'b0101);
    chk_val("dp_cycles", dp_cnt, P - B);

    // 6: leading-zero blanking (or none without the feature)
    wait_pos(1, 0);
    do_load(16'h0050, 4'h0, 4'hF);
    wait_ft();
    scan_frame();
`ifdef SEVEN_SEG_LZB_EN
    chk_val("lzb50_d3", lit_cnt[3], 0);
    chk_val("lzb50_d2", lit_cnt[2], 0);
`else
    chk_val("lzb50_d3", lit_cnt[3], P - B);
    chk_val("lzb50_d2", lit_cnt[2], P - B);
`endif
    chk_val("lzb50_d1", lit_cnt[1], P - B);
    chk_val("lzb50_d0", lit_cnt[0], P - B);
    wait_pos(1, 0);
    do_load(16'h0000, 4'h0, 4'hF);
    wait_ft();
    scan_frame();
`ifdef SEVEN_SEG_LZB_EN
    chk_val("lzb0_d1", lit_cnt[1], 0);
`else
    chk_val("lzb0_d1", lit_cnt[1], P - B);
`endif
    chk_val("lzb0_d0", lit_cnt[0], P - B);

    // reset mid-frame discards staged data and restores reset display
    wait_pos(3, 2);
    do_load(16'h7777, 4'hF, 4'hF);
    chk_val("pre_rst_pending", pending, 1'b1);
    rst_n = 1'b0; load = 1'b1; value = 16'hFFFF;
    ticks(2);
    chk_val("midrst_pending", pending, 1'b0);
    chk_val("midrst_an", an, 4'b1111);
    load = 1'b0; rst_n = 1'b1;
    ticks(3);
    chk_val("rerst_an", an, 4'b1110);
    chk_val("rerst_seg", seg, 7'b1000000);
    chk_val("rerst_dp", dp, 1'b1);
    wait_ft();
    chk_val("rerst_pending", pending, 1'b0);
    ticks(3);
    chk_val("rerst_seg2", seg, 7'b1000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
